// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared processor defines for the memory sequencer and the
// datapath registers. Holds the opcode/address field widths, the wait
// counter width, the sequencer state encoding and a RAM index-width helper.
package mem_ctrl_pkg;

  localparam int OP_W   = 8;   // opcode field width
  localparam int ADDR_W = 8;   // address field width
  localparam int CNT_W  = 4;   // wait-state counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  // Index width for a RAM of 'depth' words (at least 1 bit).
  function automatic int unsigned ram_addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// mem_ram: single-port synchronous RAM, DEPTH words of DW bits.
// Ports:
//   clk     - clock, posedge
//   nrst    - synchronous active-low reset (read register only)
//   we      - write enable; wdata written to mem[addr] at the edge
//   re      - read enable; registers mem[addr] (or zero) into rdata
//   rd_zero - with re, load zero instead of the array word
//   addr    - word index
//   wdata   - write data
//   rdata   - registered read data, holds until the next read
// The array itself has no reset.
module mem_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          we,
  input  logic          re,
  input  logic          rd_zero,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rd_zero ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory access sequencer in front of the memory data register.
// Accepts one read/write request in IDLE, inserts WAIT_CYC wait states,
// performs the access on mem_ram in XFER and signals completion in DONE.
// Ports:
//   clk, nrst  - clock (posedge) and synchronous active-low reset
//   mem_req    - access request, sampled only in IDLE
//   mem_we     - 1 = write, 0 = read, sampled with mem_req
//   mar_addr   - access address, captured on accept
//   wdata      - write data, captured on accept
//   mem_busy   - high from the cycle after accept through DONE
//   mem_done   - one-cycle completion pulse
//   mem_err    - with mem_done when the address is >= DEPTH
//   mdr_load   - one-cycle pulse on read completion
//   mem_bus    - registered read data, holds the last read value
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int OP       = OP_W,
  parameter int ADDR     = ADDR_W,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR-1:0]   mar_addr,
  input  logic [OP+ADDR-1:0] wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              mdr_load,
  output logic [OP+ADDR-1:0] mem_bus
);

  localparam int DW = OP + ADDR;
  localparam int AW = ram_addr_bits(DEPTH);
  localparam logic [ADDR:0]      DEPTH_V = (ADDR+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   WAIT_V  = CNT_W'(WAIT_CYC);

  mem_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [ADDR-1:0]  addr_q;
  logic             we_q;
  logic [DW-1:0]    wdata_q;
  logic             accept;
  logic             in_range;
  logic             ram_we;
  logic             ram_re;

  assign in_range = ({1'b0, addr_q} < DEPTH_V);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_req) begin
          accept   = 1'b1;
          state_nx = (WAIT_V == '0) ? S_XFER : S_WAIT;
        end
      end
      S_WAIT:  if (cnt == CNT_W'(1)) state_nx = S_XFER;
      S_XFER:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so that they line
  // up with the state they describe without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      mem_busy <= 1'b0;
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      mdr_load <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= mar_addr;
        we_q    <= mem_we;
        wdata_q <= wdata;
        cnt     <= WAIT_V;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 1'b1;
      end
      mem_busy <= (state_nx != S_IDLE);
      mem_done <= (state_nx == S_DONE);
      mdr_load <= (state_nx == S_DONE) && !we_q;
      mem_err  <= (state_nx == S_DONE) && !in_range;
    end
  end

  // A write coinciding with reset is dropped; out-of-range accesses never
  // touch the array and out-of-range reads return zero.
  assign ram_we = nrst && (state == S_XFER) && we_q && in_range;
  assign ram_re = (state == S_XFER) && !we_q;

  mem_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .nrst    (nrst),
    .we      (ram_we),
    .re      (ram_re),
    .rd_zero (!in_range),
    .addr    (addr_q[AW-1:0]),
    .wdata   (wdata_q),
    .rdata   (mem_bus)
  );

endmodule
